wb_bus_arbiter: RTL and testbench

//  Shares the single external Wishbone slave port between two core masters:

---
 rtl/wb_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: shares one Wishbone slave port between the instruction-fetch
// master (port 0) and the memory-stage master (port 1).
//   - Grant is held until the owning master drops cyc (no preemption).
//   - Ties go to port 1 (ROUND_ROBIN=0) or to the port not granted last (ROUND_ROBIN=1).
//   - Watchdog returns err to the owner when the slave leaves stb unanswered.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   m0_*/m1_*             master request inputs (cyc,stb,we,sel,addr,dat) and
//                         return outputs (dat,ack,err)
//   s_*                   slave request outputs and slave dat/ack/err inputs
//   grant_o               one-hot owner {m1,m0}, 00 when idle
module wb_bus_arbiter #(
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  // Last count value before the watchdog fires; unused when TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            last_grant;   // 0: port 0 granted last, 1: port 1
  logic [TO_W-1:0] wd_cnt;
  logic [TO_W-1:0] wd_cnt_next;
  logic            wd_fire;
  logic            own0;
  logic            own1;

  // Pick an owner from the current requests; used from IDLE and on release.
  function automatic state_t arbitrate(input logic c0, input logic c1, input logic last);
    state_t pick;
    pick = IDLE;
    if (c0 && c1) begin
      if (ROUND_ROBIN == 0) pick = OWN1;
      else                  pick = last ? OWN0 : OWN1;
    end else if (c1) begin
      pick = OWN1;
    end else if (c0) begin
      pick = OWN0;
    end
    return pick;
  endfunction

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: hold while the owner keeps cyc, otherwise re-arbitrate in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = arbitrate(m0_cyc_i, m1_cyc_i, last_grant);
      OWN0:    if (!m0_cyc_i) state_next = arbitrate(m0_cyc_i, m1_cyc_i, last_grant);
      OWN1:    if (!m1_cyc_i) state_next = arbitrate(m0_cyc_i, m1_cyc_i, last_grant);
      default: state_next = IDLE;
    endcase
  end

  // Outputs: slave mux, grant decode, return-path gating.
  always_comb begin
    own0     = (state == OWN0);
    own1     = (state == OWN1);
    grant_o  = {own1, own0};
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_addr_o = 32'h0;
    s_dat_o  = 32'h0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
    end
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    // Responses in a reset cycle are dropped along with the transfer.
    m0_ack_o = own0 && !rst_i && s_ack_i;
    m1_ack_o = own1 && !rst_i && s_ack_i;
    m0_err_o = own0 && !rst_i && (s_err_i || wd_fire);
    m1_err_o = own1 && !rst_i && (s_err_i || wd_fire);
  end

  // Watchdog: fire on the TIMEOUT-th unanswered strobe cycle; a same-cycle ack wins.
  always_comb begin
    wd_fire     = (TIMEOUT != 0) && s_stb_o && !s_ack_i && !s_err_i && (wd_cnt == TO_LAST);
    wd_cnt_next = wd_cnt + TO_W'(1);
    if (!s_stb_o || s_ack_i || s_err_i || wd_fire || (state_next != state) || (TIMEOUT == 0))
      wd_cnt_next = '0;
  end

  // Last-grant and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      wd_cnt <= wd_cnt_next;
      if (state_next == OWN0 && state != OWN0) last_grant <= 1'b0;
      if (state_next == OWN1 && state != OWN1) last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench: instance a (fixed priority, TIMEOUT=4) and instance b
// (round-robin, watchdog off) share one set of master/slave stimulus.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_dat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_dat;
  logic [31:0] s_dat;
  logic        s_ack, s_err;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_addr, a_s_dat;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic        a_s_cyc, a_s_stb, a_s_we;
  logic [3:0]  a_s_sel;
  logic [1:0]  a_grant;

  logic [31:0] b_m0_dat, b_m1_dat, b_s_addr, b_s_dat;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic        b_s_cyc, b_s_stb, b_s_we;
  logic [3:0]  b_s_sel;
  logic [1:0]  b_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(4), .TO_W(8)) u_a (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
    .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
    .s_addr_o(a_s_addr), .s_dat_o(a_s_dat),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(a_grant)
  );

  wb_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(0), .TO_W(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
    .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
    .s_addr_o(b_s_addr), .s_dat_o(b_s_dat),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(b_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_addr = 32'h0; m0_dat = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_addr = 32'h0; m1_dat = 32'h0;
    s_dat = 32'h0; s_ack = 0; s_err = 0;
    tick(); tick();
    check("rst_grant_a", 32'(a_grant), 32'h0);
    check("rst_grant_b", 32'(b_grant), 32'h0);
    check("rst_scyc", 32'(a_s_cyc), 32'h0);
    rst = 1'b0;
    tick();

    // m0 alone, write with ack after 2 cycles
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'h1000; m0_dat = 32'hCAFE0001;
    #1;
    check("m0_latency", 32'(a_grant), 32'h0);
    check("idle_saddr", a_s_addr, 32'h0);
    tick();
    check("m0_grant_a", 32'(a_grant), 32'h1);
    check("m0_grant_b", 32'(b_grant), 32'h1);
    check("m0_saddr", a_s_addr, 32'h1000);
    check("m0_sdat", a_s_dat, 32'hCAFE0001);
    check("m0_swe", 32'(a_s_we), 32'h1);
    check("m0_ssel", 32'(a_s_sel), 32'hF);
    check("m0_noack_early", 32'(a_m0_ack), 32'h0);
    tick();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    #1;
    check("m0_ack", 32'(a_m0_ack), 32'h1);
    check("m0_rdat", a_m0_dat, 32'hDEADBEEF);
    check("m1_no_ack", 32'(a_m1_ack), 32'h0);
    check("m0_no_err", 32'(a_m0_err), 32'h0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    tick();
    check("m0_release", 32'(a_grant), 32'h0);

    // Simultaneous requests: m1 wins in both instances, m0 waits
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h2000;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h3000;
    tick();
    check("tie_grant_a", 32'(a_grant), 32'h2);
    check("tie_grant_b", 32'(b_grant), 32'h2);
    check("tie_saddr", a_s_addr, 32'h3000);
    s_ack = 1; s_dat = 32'h12345678;
    #1;
    check("m1_ack", 32'(a_m1_ack), 32'h1);
    check("m1_rdat", a_m1_dat, 32'h12345678);
    check("m0_wait_noack", 32'(a_m0_ack), 32'h0);
    tick();
    s_ack = 0;
    check("hold_grant1", 32'(a_grant), 32'h2);
    tick();
    check("hold_grant2", 32'(a_grant), 32'h2);
    m1_cyc = 0; m1_stb = 0;
    #1;
    check("m1_no_err", 32'(a_m1_err), 32'h0);
    tick();
    // Direct handover, then watchdog on the unanswered m0 strobe
    check("handover_a", 32'(a_grant), 32'h1);
    check("handover_b", 32'(b_grant), 32'h1);
    check("wd_c1", 32'(a_m0_err), 32'h0);
    tick();
    check("wd_c2", 32'(a_m0_err), 32'h0);
    tick();
    check("wd_c3", 32'(a_m0_err), 32'h0);
    tick();
    check("wd_c4_fire", 32'(a_m0_err), 32'h1);
    check("wd_off_b", 32'(b_m0_err), 32'h0);
    check("wd_m1_clean", 32'(a_m1_err), 32'h0);
    tick();
    check("wd_c5_clear", 32'(a_m0_err), 32'h0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    check("idle_again", 32'(b_grant), 32'h0);

    // Round-robin ties from IDLE: b alternates, a always picks m1
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m1_cyc = 1;
      tick();
      check("rr_grant_b", 32'(b_grant), (r % 2 == 0) ? 32'h2 : 32'h1);
      check("fix_grant_a", 32'(a_grant), 32'h2);
      m0_cyc = 0; m1_cyc = 0;
      tick();
      check("rr_idle", 32'(b_grant), 32'h0);
    end

    // ack and err together are both forwarded
    m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1; s_err = 1;
    #1;
    check("both_ack", 32'(a_m1_ack), 32'h1);
    check("both_err", 32'(a_m1_err), 32'h1);
    check("both_m0_err", 32'(a_m0_err), 32'h0);
    s_ack = 0; s_err = 0;
    m1_cyc = 0; m1_stb = 0;
    tick();
    // Late ack while idle is discarded
    s_ack = 1;
    #1;
    check("late_ack_m1", 32'(a_m1_ack), 32'h0);
    check("late_ack_m0", 32'(a_m0_ack), 32'h0);
    s_ack = 0;

    // Reset during an m1 transfer
    m1_cyc = 1; m1_stb = 1;
    tick();
    check("pre_rst_grant", 32'(a_grant), 32'h2);
    rst = 1;
    tick();
    s_ack = 1; s_err = 1;
    #1;
    check("rst_mid_grant", 32'(a_grant), 32'h0);
    check("rst_mid_scyc", 32'(a_s_cyc), 32'h0);
    check("rst_mid_ack", 32'(a_m1_ack), 32'h0);
    check("rst_mid_err", 32'(a_m1_err), 32'h0);
    s_ack = 0; s_err = 0;
    rst = 0;
    tick();
    check("post_rst_grant", 32'(b_grant), 32'h2);
    m1_cyc = 0; m1_stb = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
